// File: rtl/bundle_sequencer.sv
// Bundle sequencer: streams D-bit hypervectors into an external bank of D
// signed up/down counters, then reads the counter signs back as the
// bitwise majority of the accepted vectors.
module bundle_sequencer #(
  parameter int D  = 32,
  parameter int W  = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_vecs,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_data,
  output logic          ctr_rst,
  output logic          ctr_update,
  output logic [D-1:0]  ctr_bits,
  input  logic [D-1:0]  ctr_sign,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] vec_cnt
);

  // The counters must hold +/-(2^NW - 1) without wrapping into the sign bit.
  if (((64'd1 << NW) - 64'd1) >= (64'd1 << (W - 1))) begin : g_width_check
    $error("bundle_sequencer: W too small for NW");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    OUTPUT
  } state_t;

  state_t        state_q;
  logic [NW-1:0] rem_q;
  logic [NW-1:0] vec_cnt_q;
  logic [D-1:0]  out_data_q;
  logic          out_valid_q;
  logic          xfer;

  // Input side is only open while accumulating; reset closes it immediately.
  assign in_ready   = (state_q == ACCUM) && !rst;
  assign xfer       = in_valid && in_ready && !abort;
  assign ctr_update = xfer;

  // Counter bits follow the input word in ACCUM and are forced low elsewhere.
  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    assign ctr_bits[gi] = in_data[gi] & in_ready;
  end

  // Counter bank is cleared during sequencer reset and for the CLEAR cycle.
  assign ctr_rst   = rst || (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign vec_cnt   = vec_cnt_q;
  // Completion is flagged in the handshake cycle itself.
  assign done      = out_valid_q && out_ready && !abort && !rst;

  // Job control FSM: reset beats abort, abort beats start and everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      vec_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      // Abort in IDLE is a no-op apart from suppressing a simultaneous start.
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q     <= n_vecs;
            vec_cnt_q <= '0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= (rem_q == '0) ? SETTLE : ACCUM;
        end
        ACCUM: begin
          if (xfer) begin
            rem_q     <= rem_q - NW'(1);
            vec_cnt_q <= vec_cnt_q + NW'(1);
            if (rem_q == NW'(1)) begin
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // The last update has landed in the counters by now; a negative
          // counter means the lane saw more 1s than 0s.
          out_data_q  <= ctr_sign;
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Self-checking bench for bundle_sequencer: emulates the counter bank,
// runs directed table jobs, hand-written corner sequences and random jobs.
module tb_bundle_sequencer;
  localparam int D  = 32;
  localparam int W  = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] n_vecs;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_data;
  logic          ctr_rst;
  logic          ctr_update;
  logic [D-1:0]  ctr_bits;
  logic [D-1:0]  ctr_sign;
  logic          busy;
  logic          done;
  logic [NW-1:0] vec_cnt;

  always #5 clk = ~clk;

  bundle_sequencer #(.D(D), .W(W), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_vecs(n_vecs), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ctr_rst(ctr_rst), .ctr_update(ctr_update), .ctr_bits(ctr_bits),
    .ctr_sign(ctr_sign), .busy(busy), .done(done), .vec_cnt(vec_cnt)
  );

  // External counter bank: +1 for a 0 bit, -1 for a 1 bit, sign bit fed back.
  logic signed [W-1:0] ctr [D];
  for (genvar gi = 0; gi < D; gi++) begin : g_ctr
    always @(posedge clk) begin
      if (ctr_rst) ctr[gi] <= '0;
      else if (ctr_update) ctr[gi] <= ctr_bits[gi] ? ctr[gi] - W'(1) : ctr[gi] + W'(1);
    end
    assign ctr_sign[gi] = ctr[gi][W-1];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [D-1:0] job_q[$];

  typedef struct {
    int              n;
    logic [3:0][D-1:0] v;
    logic [D-1:0]    exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; in_valid = 0; in_data = '0; out_ready = 0; n_vecs = '0;
  endtask

  // Reference: lane result is 1 iff strictly more than half the vectors had a 1.
  function automatic logic [D-1:0] majority(input int n);
    logic [D-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < D; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(job_q[k][b]);
      r[b] = (2 * ones > n);
    end
    return r;
  endfunction

  // One job from start to handshake (or to a reset injected in OUTPUT).
  // vmode: 0 back-to-back, 1 random valid, 2 valid on odd cycles.
  task automatic run_job(input int n, input int vmode, input int stall, input bit timed,
                         input logic [D-1:0] exp, input int restart_at, input bit rst_in_out);
    int cyc, idx, upd, dones, out_first;
    bit fin;
    logic [D-1:0] held;
    tick();
    idle_inputs();
    start = 1; n_vecs = NW'(n);
    #1;
    chk("busy_before_start", busy, 0);
    cyc = 0; idx = 0; upd = 0; dones = 0; out_first = -1; fin = 0; held = '0;
    while (!fin) begin
      tick();
      cyc++;
      start     = (cyc == restart_at);
      n_vecs    = start ? NW'(1) : NW'($urandom);
      in_valid  = (idx < n) && (vmode == 0 || (vmode == 1 && $urandom_range(0, 1) == 1) ||
                                (vmode == 2 && cyc[0]));
      in_data   = (idx < n) ? job_q[idx] : D'($urandom);
      out_ready = !rst_in_out && (stall == 0 || (out_first >= 0 && cyc - out_first >= stall));
      #1;
      if (cyc == 1) begin
        chk("ctr_rst_in_clear", ctr_rst, 1);
        chk("vec_cnt_zeroed", vec_cnt, 0);
      end else begin
        chk("ctr_rst_low", ctr_rst, 0);
      end
      if (ctr_update) begin
        chk("update_needs_valid", in_valid, 1);
        chk("ctr_bits", ctr_bits, in_data);
        upd++; idx++;
      end
      if (done) dones++;
      if (out_valid) begin
        if (out_first < 0) begin
          out_first = cyc;
          held = out_data;
          chk("out_data", out_data, exp);
          chk("vec_cnt_final", vec_cnt, n);
          chk("update_count", upd, n);
          if (timed) chk("latency", cyc, n + 3);
        end else begin
          chk("out_hold", out_data, held);
        end
        if (rst_in_out && cyc - out_first == 1) begin
          rst = 1;
          #1;
          chk("ctr_rst_in_rst", ctr_rst, 1);
          chk("done_in_rst", done, 0);
          tick();
          idle_inputs();
          #1;
          chk("rst_ctr_rst", ctr_rst, 1);
          chk("rst_out_valid", out_valid, 0);
          chk("rst_done", done, 0);
          chk("rst_busy", busy, 0);
          chk("rst_in_ready", in_ready, 0);
          chk("rst_ctr_update", ctr_update, 0);
          chk("rst_ctr_bits", ctr_bits, 0);
          chk("rst_out_data", out_data, 0);
          chk("rst_vec_cnt", vec_cnt, 0);
          tick();
          rst = 0;
          #1;
          chk("post_rst_ctr_rst", ctr_rst, 0);
          fin = 1;
        end else if (out_ready) begin
          chk("done_on_handshake", done, 1);
          fin = 1;
        end else begin
          chk("no_done_stalled", done, 0);
        end
      end
      if (!fin && cyc > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: got no handshake after %0d cycles, expected within %0d", cyc, 300);
        fin = 1;
      end
    end
    if (!rst_in_out) begin
      tick();
      idle_inputs();
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("done_count", dones, 1);
      chk("out_data_kept", out_data, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, vm;
    rst = 1;
    idle_inputs();
    tbl[0] = '{3, {32'h0, 32'h1, 32'h3, 32'hF}, 32'h0000_0003};
    tbl[1] = '{2, {32'h0, 32'h0, 32'h0000_FFFF, 32'hFFFF_0000}, 32'h0};
    tbl[2] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0};
    tbl[3] = '{1, {32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5}, 32'hA5A5_A5A5};
    tbl[4] = '{4, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'hFFFF_FFFF};
    tbl[5] = '{4, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'h0};

    // Reset state
    tick();
    tick();
    chk("reset_ctr_rst", ctr_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_vec_cnt", vec_cnt, 0);
    rst = 0;
    tick();
    chk("ctr_rst_released", ctr_rst, 0);

    // Directed table, back-to-back input with out_ready high
    for (int i = 0; i < 6; i++) begin
      job_q.delete();
      for (int k = 0; k < tbl[i].n; k++) job_q.push_back(tbl[i].v[k]);
      run_job(tbl[i].n, 0, 0, 1, tbl[i].exp, -1, 0);
    end

    // Toggling valid with a 5-cycle output stall
    job_q.delete();
    for (int k = 0; k < 4; k++) job_q.push_back($urandom);
    run_job(4, 2, 5, 0, majority(4), -1, 0);

    // Abort after 2 of 5 transfers, then a 1-vector job
    job_q.delete();
    for (int k = 0; k < 5; k++) job_q.push_back($urandom);
    tick(); idle_inputs(); start = 1; n_vecs = 5;
    tick(); start = 0;
    tick(); in_valid = 1; in_data = job_q[0]; #1; chk("abort_xfer0", ctr_update, 1);
    tick(); in_data = job_q[1]; #1; chk("abort_xfer1", ctr_update, 1);
    tick(); in_data = job_q[2]; abort = 1; #1;
    chk("abort_no_update", ctr_update, 0);
    chk("abort_no_done", done, 0);
    tick(); idle_inputs(); #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ready", in_ready, 0);
    chk("abort_idle_done", done, 0);
    job_q.delete();
    job_q.push_back(32'hA5A5_A5A5);
    run_job(1, 0, 0, 1, 32'hA5A5_A5A5, -1, 0);

    // Abort wins over start in IDLE
    tick(); idle_inputs(); start = 1; abort = 1; n_vecs = 3;
    tick(); idle_inputs(); #1;
    chk("abort_beats_start_busy", busy, 0);
    chk("abort_beats_start_clear", ctr_rst, 0);

    // Start during ACCUM ignored, then reset during OUTPUT
    job_q.delete();
    for (int k = 0; k < 4; k++) job_q.push_back($urandom);
    run_job(4, 0, 0, 1, majority(4), 3, 1);

    // Random jobs against the majority model
    for (int j = 0; j < 25; j++) begin
      n  = $urandom_range(0, 12);
      vm = $urandom_range(0, 1);
      job_q.delete();
      for (int k = 0; k < n; k++) job_q.push_back($urandom);
      run_job(n, vm, $urandom_range(0, 3), (vm == 0), majority(n), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
